// File: rtl/lock_pkg.sv
// Shared types and constants for the three-digit lock controller.
// Pure declarations: no logic, no latency.
package lock_pkg;

    typedef enum logic [1:0] {
        ST_UNLOCKED = 2'd0,
        ST_SET      = 2'd1,
        ST_LOCKED   = 2'd2,
        ST_ALARM    = 2'd3
    } state_t;

    localparam logic [3:0] KEY_ENTER = 4'hA;
    localparam logic [3:0] KEY_CLEAR = 4'hB;
    localparam logic [3:0] KEY_MODE  = 4'hC;

    localparam int DIGITS = 3;

    function automatic logic is_digit(input logic [3:0] k);
        return k <= 4'd9;
    endfunction

endpackage

// File: rtl/lock_timer.sv
// Loadable down-counter that stops at zero; busy while the count is nonzero.
// Load takes effect on the next edge; no backpressure, load wins over decrement.
module lock_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] count,
    output logic         busy
);

    logic [W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (count_q != '0) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;
    assign busy  = (count_q != '0);

endmodule

// File: rtl/lock_ctrl.sv
// Digital lock sequencer: keypad entry, stored code, lock/set/alarm FSM, display controls.
// Every key takes effect on the next edge (1 cycle); a key can be accepted every cycle, no backpressure.
module lock_ctrl
    import lock_pkg::*;
#(
    parameter int          MAX_TRIES   = 3,
    parameter int          LOCKOUT_CYC = 1000,
    parameter int          SHOW_CYC    = 500,
    parameter logic [11:0] RESET_PASS  = 12'h000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        key_valid,
    input  logic [3:0]  key_code,
    output logic [11:0] pass_in,
    output logic [11:0] pass_set,
    output logic        mode,
    output logic        L,
    output logic        show,
    output logic        alarm,
    output logic [2:0]  tries
);

    localparam int LW = $clog2(LOCKOUT_CYC + 1);
    localparam int SW = $clog2(SHOW_CYC + 1);
    localparam logic [1:0] CNT_FULL = 2'(DIGITS);

    state_t      state_q, state_d;
    logic [11:0] pass_in_q, pass_in_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [11:0] pass_set_q, pass_set_d;
    logic [2:0]  tries_q, tries_d, tries_inc;
    logic        mode_q, mode_d, l_q, l_d, show_q, show_d, alarm_q, alarm_d;
    logic        show_load, lock_load, entry_full;
    logic [SW-1:0] show_count;
    logic [LW-1:0] lock_count;
    logic        show_busy, lock_busy;

    lock_timer #(.W(SW)) u_show_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (show_load),
        .load_val (SW'(SHOW_CYC)),
        .count    (show_count),
        .busy     (show_busy)
    );

    lock_timer #(.W(LW)) u_lock_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (lock_load),
        .load_val (LW'(LOCKOUT_CYC)),
        .count    (lock_count),
        .busy     (lock_busy)
    );

    always_comb begin
        state_d    = state_q;
        pass_in_d  = pass_in_q;
        cnt_d      = cnt_q;
        pass_set_d = pass_set_q;
        tries_d    = tries_q;
        show_load  = 1'b0;
        lock_load  = 1'b0;
        tries_inc  = tries_q + 3'd1;
        entry_full = (cnt_q == CNT_FULL);

        case (state_q)
            ST_UNLOCKED, ST_SET, ST_LOCKED: begin
                if (key_valid) begin
                    if (is_digit(key_code)) begin
                        pass_in_d = {pass_in_q[7:0], key_code};
                        cnt_d     = entry_full ? CNT_FULL : cnt_q + 2'd1;
                    end else if (key_code == KEY_CLEAR) begin
                        pass_in_d = '0;
                        cnt_d     = '0;
                    end else if (key_code == KEY_MODE && state_q != ST_LOCKED) begin
                        state_d   = (state_q == ST_UNLOCKED) ? ST_SET : ST_UNLOCKED;
                        pass_in_d = '0;
                        cnt_d     = '0;
                    end else if (key_code == KEY_ENTER) begin
                        if (state_q == ST_UNLOCKED) begin
                            state_d   = ST_LOCKED;
                            pass_in_d = '0;
                            cnt_d     = '0;
                        end else if (entry_full) begin
                            pass_in_d = '0;
                            cnt_d     = '0;
                            if (state_q == ST_SET) begin
                                pass_set_d = pass_in_q;
                                show_load  = 1'b1;
                                state_d    = ST_UNLOCKED;
                            end else if (pass_in_q == pass_set_q) begin
                                state_d = ST_UNLOCKED;
                                tries_d = '0;
                            end else begin
                                tries_d = tries_inc;
                                if (tries_inc == 3'(MAX_TRIES)) begin
                                    state_d   = ST_ALARM;
                                    lock_load = 1'b1;
                                end
                            end
                        end
                    end
                end
            end
            ST_ALARM: begin
                pass_in_d = '0;
                cnt_d     = '0;
                // Leave on the edge where the lockout count runs out; an idle timer also releases.
                if (!lock_busy || lock_count == LW'(1)) begin
                    state_d = ST_LOCKED;
                    tries_d = '0;
                end
            end
            default: begin
                state_d   = ST_UNLOCKED;
                pass_in_d = '0;
                cnt_d     = '0;
            end
        endcase

        mode_d  = (state_d == ST_SET);
        l_d     = (state_d == ST_LOCKED) || (state_d == ST_ALARM);
        alarm_d = (state_d == ST_ALARM);
        // Mirrors the timer's next count being nonzero, so show tracks the timer exactly.
        show_d  = show_load ? (SHOW_CYC != 0) : (show_busy && show_count != SW'(1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_UNLOCKED;
            pass_in_q  <= '0;
            cnt_q      <= '0;
            pass_set_q <= RESET_PASS;
            tries_q    <= '0;
            mode_q     <= 1'b0;
            l_q        <= 1'b0;
            show_q     <= 1'b0;
            alarm_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            pass_in_q  <= pass_in_d;
            cnt_q      <= cnt_d;
            pass_set_q <= pass_set_d;
            tries_q    <= tries_d;
            mode_q     <= mode_d;
            l_q        <= l_d;
            show_q     <= show_d;
            alarm_q    <= alarm_d;
        end
    end

    assign pass_in  = pass_in_q;
    assign pass_set = pass_set_q;
    assign mode     = mode_q;
    assign L        = l_q;
    assign show     = show_q;
    assign alarm    = alarm_q;
    assign tries    = tries_q;

endmodule

// File: tb/tb_lock_ctrl.sv
// Bench for lock_ctrl: directed key sequences, cycle-stamped behavioural model, literal spot checks.
module tb_lock_ctrl;

    localparam int          MAXT  = 3;
    localparam int          LOCK  = 30;
    localparam int          SHOWC = 40;
    localparam logic [11:0] RP    = 12'h456;

    localparam int M_U = 0, M_S = 1, M_L = 2, M_A = 3;

    logic        clk = 1'b0;
    logic        rst, key_valid;
    logic [3:0]  key_code;
    logic [11:0] pass_in, pass_set;
    logic        mode, L, show, alarm;
    logic [2:0]  tries;

    always #5 clk = ~clk;

    lock_ctrl #(
        .MAX_TRIES   (MAXT),
        .LOCKOUT_CYC (LOCK),
        .SHOW_CYC    (SHOWC),
        .RESET_PASS  (RP)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .key_valid (key_valid),
        .key_code  (key_code),
        .pass_in   (pass_in),
        .pass_set  (pass_set),
        .mode      (mode),
        .L         (L),
        .show      (show),
        .alarm     (alarm),
        .tries     (tries)
    );

    int n_pass = 0;
    int n_chk  = 0;

    // Model: entry kept as a list of digits, timers as absolute edge stamps.
    int          m_st = M_U;
    int          q[$];
    logic [11:0] m_set = RP;
    int          m_tries = 0;
    int          cyc = 0;
    int          show_until = 0;
    int          alarm_end = 0;
    bit          mdl_ok = 0;

    function automatic logic [11:0] entry();
        logic [11:0] p = '0;
        foreach (q[i]) p = {p[7:0], 4'(q[i])};
        return p;
    endfunction

    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            m_st = M_U; q.delete(); m_set = RP; m_tries = 0;
            show_until = 0; alarm_end = 0; mdl_ok = 1;
        end else if (m_st == M_A) begin
            if (cyc == alarm_end) begin
                m_st = M_L; m_tries = 0;
            end
        end else if (key_valid) begin
            if (key_code <= 4'd9) begin
                q.push_back(int'(key_code));
                if (q.size() > 3) void'(q.pop_front());
            end else if (key_code == 4'hB) begin
                q.delete();
            end else if (key_code == 4'hC) begin
                if (m_st == M_U) begin m_st = M_S; q.delete(); end
                else if (m_st == M_S) begin m_st = M_U; q.delete(); end
            end else if (key_code == 4'hA) begin
                if (m_st == M_U) begin
                    m_st = M_L; q.delete();
                end else if (q.size() == 3) begin
                    if (m_st == M_S) begin
                        m_set = entry(); show_until = cyc + SHOWC; m_st = M_U;
                    end else if (entry() == m_set) begin
                        m_st = M_U; m_tries = 0;
                    end else begin
                        m_tries++;
                        if (m_tries == MAXT) begin
                            m_st = M_A; alarm_end = cyc + LOCK;
                        end
                    end
                    q.delete();
                end
            end
        end
    end

    always @(negedge clk) begin
        logic [30:0] exp_v, act_v;
        if (mdl_ok) begin
            exp_v = {entry(), m_set, m_st == M_S, m_st == M_L || m_st == M_A,
                     cyc < show_until, m_st == M_A, 3'(m_tries)};
            act_v = {pass_in, pass_set, mode, L, show, alarm, tries};
            n_chk++;
            if (act_v === exp_v) n_pass++;
            else $display("FAIL cycle %0d outputs {pass_in,pass_set,mode,L,show,alarm,tries}: got %h want %h",
                          cyc, act_v, exp_v);
        end
    end

    task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h want %h", name, act, exp);
    endtask

    task automatic key(input logic [3:0] c);
        key_valid = 1'b1;
        key_code  = c;
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        key_valid = 1'b0;
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic press(input logic [3:0] c);
        key(c);
        idle(1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        rst = 1'b1; key_valid = 1'b0; key_code = 4'h0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check("reset pass_set", pass_set, RP);
        check("reset pass_in", pass_in, 12'h000);
        check("reset flags", 12'({alarm, show, L, mode, tries}), 12'h000);

        press(4'd1); press(4'd2); press(4'd3);
        check("entry 123", pass_in, 12'h123);
        press(4'hA);
        check("enter locks", 12'(L), 12'h1);
        press(4'd4); press(4'd5); press(4'd6); press(4'hA);
        check("unlock with reset code", 12'(L), 12'h0);

        press(4'hC); press(4'd1); press(4'd2); press(4'd3);
        key(4'hA);
        check("store 123", pass_set, 12'h123);
        n = 0;
        key_valid = 1'b0;
        while (show === 1'b1 && n < 200) begin n++; @(posedge clk); #1; end
        check("show length", 12'(n), 12'(SHOWC));

        press(4'hA);
        press(4'd1); press(4'd2); press(4'hA);
        check("short entry ignored in locked", 12'(L), 12'h1);
        press(4'hB);
        press(4'd1); press(4'd2); press(4'd3); press(4'hA);
        check("unlock 123 L", 12'(L), 12'h0);
        check("unlock 123 tries", 12'(tries), 12'h0);
        press(4'd4); press(4'd1); press(4'd2); press(4'd3);
        check("saturated entry", pass_in, 12'h123);
        press(4'hB);
        press(4'hA);

        for (int k = 1; k <= MAXT; k++) begin
            press(4'd9); press(4'd9); press(4'd9);
            key(4'hA);
            key_valid = 1'b0;
            if (k < MAXT) check("tries step", 12'(tries), 12'(k));
            else          check("alarm rises", 12'(alarm), 12'h1);
        end
        n = 0;
        while (alarm === 1'b1 && n < 200) begin
            key_valid = 1'b1;
            key_code  = 4'(n % 10);
            if (n == 5) check("pass_in held in alarm", pass_in, 12'h000);
            n++;
            @(posedge clk); #1;
        end
        key_valid = 1'b0;
        check("alarm length", 12'(n), 12'(LOCK));
        check("after alarm L", 12'(L), 12'h1);
        check("after alarm tries", 12'(tries), 12'h0);
        check("after alarm pass_in", pass_in, 12'h000);

        press(4'd1); press(4'd2); press(4'd3); press(4'hA);
        key(4'hC); key(4'd7); key(4'd7); key(4'd1); key(4'hA);
        key(4'hA);
        for (int k = 0; k < MAXT; k++) begin
            key(4'd9); key(4'd9); key(4'd9); key(4'hA);
        end
        idle(1);
        check("alarm before reset", 12'(alarm), 12'h1);
        check("show before reset", 12'(show), 12'h1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("mid reset flags", 12'({alarm, show, L, mode, tries}), 12'h000);
        check("mid reset pass_set", pass_set, RP);

        press(4'hC); press(4'd1); press(4'd2); press(4'hA);
        check("short enter stays in set", 12'(mode), 12'h1);
        check("short enter keeps pass_set", pass_set, RP);
        press(4'hB);
        check("clear in set", pass_in, 12'h000);
        press(4'hC);
        check("abort set", 12'(mode), 12'h0);
        check("abort keeps pass_set", pass_set, RP);

        key(4'hC); key(4'd7); key(4'hE); key(4'd8); key(4'd9); key(4'hA);
        idle(1);
        check("back-to-back store", pass_set, 12'h789);
        key(4'hE); idle(1);
        check("key E in unlocked", 12'({L, mode}), 12'h0);
        press(4'hA);
        key(4'hE); idle(1);
        check("key E in locked", 12'({L, mode}), 12'h2);
        press(4'd7); press(4'd8); press(4'd9); press(4'hA);
        check("unlock 789", 12'(L), 12'h0);

        idle(3);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
